// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults, count-width helper and the default stage
// record for the reg_pipe delay line.
package reg_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One pipeline stage: data word plus its valid qualifier.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 valid;
    } stage_t;

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: a single data+valid register of the pipe.
// The stored record type is a type parameter so the top can hand in a
// record sized to its own WIDTH; it defaults to the package record.
// Flush clears only the valid bit and leaves the data word in place.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter type  stg_t   = reg_pipe_pkg::stage_t,
    parameter stg_t RST_STG = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic flush_i,
    input  logic en_i,
    input  stg_t stg_i,
    output stg_t stg_o
);

    stg_t stg_d;
    stg_t stg_q;

    // Next-state: flush beats advance; otherwise hold.
    always_comb begin
        stg_d = stg_q;
        if (flush_i) begin
            stg_d.valid = 1'b0;
        end else if (en_i) begin
            stg_d = stg_i;
        end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stg_q <= RST_STG;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign stg_o = stg_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: WIDTH-bit, DEPTH-stage delay line with per-stage valid,
// stall (en_i), flush and an occupancy count of valid stages.
// Outputs come straight from flops; there is no input-to-output path.
// Optional macro REG_PIPE_TAP_EN adds taps_o / vld_taps_o exposing every
// stage for debug and forwarding.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic                      flush_i,
    input  logic [WIDTH-1:0]          d_i,
    input  logic                      valid_i,
    output logic [WIDTH-1:0]          q_o,
    output logic                      valid_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
`ifdef REG_PIPE_TAP_EN
    ,
    output logic [DEPTH*WIDTH-1:0]    taps_o,
    output logic [DEPTH-1:0]          vld_taps_o
`endif
);

    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
    } stage_w_t;

    localparam stage_w_t RST_STG = '{data: RST_VAL, valid: 1'b0};

    stage_w_t stg_in  [DEPTH];
    stage_w_t stg_out [DEPTH];

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    logic          vld_last;

    // Chain of stages: stage 0 takes the input word, stage k the output of k-1.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stg_in[k] = '{data: d_i, valid: valid_i};
        end else begin : g_body
            assign stg_in[k] = stg_out[k-1];
        end

        reg_pipe_stage #(
            .stg_t   (stage_w_t),
            .RST_STG (RST_STG)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush_i (flush_i),
            .en_i    (en_i),
            .stg_i   (stg_in[k]),
            .stg_o   (stg_out[k])
        );
    end

    assign vld_last = stg_out[DEPTH-1].valid;

    // Occupancy: a valid word entering adds one, a valid word leaving removes one.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(valid_i) - CW'(vld_last);
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o     = stg_out[DEPTH-1].data;
    assign valid_o = vld_last;
    assign count_o = cnt_q;

`ifdef REG_PIPE_TAP_EN
    // Flatten every stage onto the debug taps.
    for (genvar t = 0; t < DEPTH; t++) begin : g_tap
        assign taps_o[t*WIDTH +: WIDTH] = stg_out[t].data;
        assign vld_taps_o[t]            = stg_out[t].valid;
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed vector table followed by randomized traffic checked
// against a queue-based model of the delay line.
module tb_reg_pipe;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 3;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic       clk;
    logic       reset;
    logic       en_i;
    logic       flush_i;
    logic [7:0] d_i;
    logic       valid_i;
    logic [7:0] q_o;
    logic       valid_o;
    logic [1:0] count_o;
`ifdef REG_PIPE_TAP_EN
    logic [DEPTH*WIDTH-1:0] taps_o;
    logic [DEPTH-1:0]       vld_taps_o;
`endif

    reg_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en_i),
        .flush_i (flush_i),
        .d_i     (d_i),
        .valid_i (valid_i),
        .q_o     (q_o),
        .valid_o (valid_o),
        .count_o (count_o)
`ifdef REG_PIPE_TAP_EN
        ,
        .taps_o     (taps_o),
        .vld_taps_o (vld_taps_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the pipe is a queue of DEPTH entries, index 0 newest.
    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } ent_t;

    ent_t m_q[$];

    function automatic int model_cnt();
        int c = 0;
        foreach (m_q[i]) if (m_q[i].v) c++;
        return c;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one clock edge with the given inputs and advance the model.
    task automatic step(input logic rst_n, input logic en, input logic fl,
                        input logic [7:0] d, input logic v);
        ent_t e;
        reset   = rst_n;
        en_i    = en;
        flush_i = fl;
        d_i     = d;
        valid_i = v;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            foreach (m_q[i]) m_q[i] = '{d: RST_VAL, v: 1'b0};
        end else if (fl) begin
            foreach (m_q[i]) m_q[i].v = 1'b0;
        end else if (en) begin
            e = '{d: d, v: v};
            m_q.push_front(e);
            void'(m_q.pop_back());
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       fl;
        logic [7:0] d;
        logic       v;
        logic [7:0] eq;
        logic       ev;
        int         ecnt;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic en, input logic fl,
                                input logic [7:0] d, input logic v,
                                input logic [7:0] eq, input logic ev, input int ecnt,
                                input string nm);
        vec_t r;
        r.rst_n = rst_n; r.en = en; r.fl = fl; r.d = d; r.v = v;
        r.eq = eq; r.ev = ev; r.ecnt = ecnt; r.nm = nm;
        return r;
    endfunction

    initial begin
        reset = 1'b0; en_i = 1'b0; flush_i = 1'b0; d_i = '0; valid_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_q.push_back('{d: RST_VAL, v: 1'b0});

        //            rst en fl  d      v   q      v   cnt
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'hA5, 0, 0, "reset0"));
        vecs.push_back(mk(0, 1, 0, 8'h55, 1, 8'hA5, 0, 0, "reset1"));
        vecs.push_back(mk(1, 1, 0, 8'h01, 1, 8'hA5, 0, 1, "fill1"));
        vecs.push_back(mk(1, 1, 0, 8'h02, 1, 8'hA5, 0, 2, "fill2"));
        vecs.push_back(mk(1, 1, 0, 8'h03, 1, 8'h01, 1, 3, "fill3"));
        vecs.push_back(mk(1, 1, 0, 8'h04, 0, 8'h02, 1, 2, "drain1"));
        vecs.push_back(mk(1, 1, 0, 8'h05, 1, 8'h03, 1, 2, "refill1"));
        vecs.push_back(mk(1, 1, 0, 8'h06, 1, 8'h04, 0, 2, "bubble_out"));
        vecs.push_back(mk(1, 1, 0, 8'h07, 1, 8'h05, 1, 3, "full"));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 0, 8'hEE, 1, 8'h05, 1, 3, "stall"));
        vecs.push_back(mk(1, 1, 0, 8'h08, 1, 8'h06, 1, 3, "resume_full"));
        vecs.push_back(mk(1, 1, 1, 8'hFF, 1, 8'h06, 0, 0, "flush"));
        vecs.push_back(mk(1, 1, 0, 8'h10, 1, 8'h07, 0, 1, "alt0"));
        vecs.push_back(mk(1, 1, 0, 8'h11, 0, 8'h08, 0, 1, "alt1"));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h10, 1, 2, "alt2"));
        vecs.push_back(mk(1, 1, 0, 8'h13, 0, 8'h11, 0, 1, "alt3"));
        vecs.push_back(mk(1, 1, 0, 8'h14, 1, 8'h12, 1, 2, "alt4"));
        vecs.push_back(mk(1, 1, 0, 8'h15, 1, 8'h13, 0, 2, "alt5"));
        vecs.push_back(mk(1, 1, 0, 8'h16, 1, 8'h14, 1, 3, "alt6"));
        vecs.push_back(mk(0, 1, 0, 8'h77, 1, 8'hA5, 0, 0, "reset_mid"));

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].fl, vecs[i].d, vecs[i].v);
            check({vecs[i].nm, ".q"},   int'(q_o),     int'(vecs[i].eq));
            check({vecs[i].nm, ".v"},   int'(valid_o), int'(vecs[i].ev));
            check({vecs[i].nm, ".cnt"}, int'(count_o), vecs[i].ecnt);
        end

        // Stall latency: one word with gaps of en_i low still exits intact.
        step(1, 1, 0, 8'h3C, 1);
        step(1, 0, 0, 8'h00, 0);
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        check("stall_lat.pre_v", int'(valid_o), 0);
        step(1, 1, 0, 8'h00, 0);
        check("stall_lat.q", int'(q_o), 8'h3C);
        check("stall_lat.v", int'(valid_o), 1);
        step(1, 1, 0, 8'h00, 0);
        check("stall_lat.empty_cnt", int'(count_o), 0);
        step(1, 1, 0, 8'h00, 0);
        check("empty_stays", int'(count_o), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic rst_n, en, fl, v;
            logic [7:0] d;
            rst_n = ($urandom_range(0, 99) >= 2);
            en    = ($urandom_range(0, 99) < 75);
            fl    = ($urandom_range(0, 99) < 5);
            v     = ($urandom_range(0, 99) < 60);
            d     = 8'($urandom);
            step(rst_n, en, fl, d, v);
            check("rnd.q",   int'(q_o),     int'(m_q[DEPTH-1].d));
            check("rnd.v",   int'(valid_o), int'(m_q[DEPTH-1].v));
            check("rnd.cnt", int'(count_o), model_cnt());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised register pipeline: the multi-bit, multi-stage successor to the single-bit DFF. It delays a WIDTH-bit data word by DEPTH clock cycles, tracks a valid bit per stage, and supports stall (enable), flush and an occupancy count. It serves as the generic retiming/delay element in datapaths that need matched latency on parallel paths.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 3, number of register stages (≥1)
- RST_VAL, '0, WIDTH-bit value loaded into every data stage on reset
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (asserted = 0, sampled on rising clk)
- en_i  input  1  advance enable; 0 stalls the whole pipe
- flush_i  input  1  invalidate all stages
- d_i  input  WIDTH  data in
- valid_i  input  1  valid qualifier for d_i
- q_o  output  WIDTH  data out of last stage
- valid_o  output  1  valid bit of last stage
- count_o  output  $clog2(DEPTH+1)  number of valid stages currently held

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], cnt.
- Priority per rising edge: reset low > flush_i > en_i > hold.
- reset low: data[k] ← RST_VAL, vld[k] ← 0, cnt ← 0, for all k.
- flush_i = 1 (reset high): vld[k] ← 0 all k, cnt ← 0; data[k] unchanged; en_i and d_i ignored that cycle.
- en_i = 1 (no reset/flush): data[0] ← d_i, vld[0] ← valid_i; data[k] ← data[k-1], vld[k] ← vld[k-1] for k ≥ 1; cnt ← cnt + valid_i − vld[DEPTH-1].
- en_i = 0: all state holds, including cnt; d_i/valid_i dropped.
- Data captured regardless of valid_i; no bubble collapsing — bubbles travel through the pipe.
- Outputs registered-direct: q_o = data[DEPTH-1], valid_o = vld[DEPTH-1], count_o = cnt. No combinational path input→output.
- cnt never exceeds DEPTH and never underflows (invariant: cnt = popcount(vld)).

## Timing
- Reset values: q_o = RST_VAL, valid_o = 0, count_o = 0 (visible the cycle after reset sampled low).
- Latency: word presented at edge N with en_i high every edge appears on q_o after edge N+DEPTH−1 (i.e. DEPTH edges of en_i including capture edge).
- Stalled cycles add one cycle each to latency; no data lost while en_i = 0.
- Full pipe (cnt = DEPTH) with en_i=1, valid_i=1: out word exits, in word enters, cnt stays DEPTH.
- Empty pipe with valid_i=0: cnt stays 0.
- flush_i and en_i together: flush wins; incoming word discarded.
- Reset mid-stream: all valid data lost, q_o returns to RST_VAL next cycle.
- DEPTH = 1: single stage, cnt width 1.

## Configuration
- REG_PIPE_TAP_EN defined: extra output taps_o, DEPTH*WIDTH bits, taps_o[k*WIDTH +: WIDTH] = data[k]; plus vld_taps_o, DEPTH bits = vld. Used for debug and forwarding.
- Not defined: ports absent; behaviour otherwise identical.

## Structure
- Package reg_pipe_pkg: default WIDTH/DEPTH constants, count-width function cnt_w(depth) = $clog2(depth+1), stage struct typedef (data + valid) used by the sub-module.
- Sub-module reg_pipe_stage: one stage (data + valid flop) with sync active-low reset, flush (clears valid only) and enable; reg_pipe instantiates DEPTH of these via generate and owns the counter.

## Test plan
(WIDTH=8, DEPTH=3, RST_VAL=8'hA5)
- Reset low 2 cycles → q_o=8'hA5, valid_o=0, count_o=0.
- en_i=1, feed 8'h01,8'h02,8'h03 with valid_i=1 on 3 consecutive edges → 8'h01 on q_o with valid_o=1 after third edge; count_o=3; next edge with valid_i=0 → q_o=8'h02, count_o=2.
- Full pipe, drop en_i for 4 cycles → q_o, valid_o, count_o unchanged; resume → sequence continues without loss.
- Full pipe, flush_i=1 with en_i=1, d_i=8'hFF → valid_o=0, count_o=0, q_o keeps last data; 8'hFF never appears valid.
- Alternate valid_i 1/0 (8'h10,8'h11,8'h12,8'h13) → valid_o toggles after 3-cycle latency, count_o alternates 1/2, never >3.
- Reset low mid-stream with count_o=3 → next cycle q_o=8'hA5, valid_o=0, count_o=0.
